// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// MulDivUnit -- iterative multiply / divide unit for the E stage.
//
// Purpose:
//   Executes MULT, MULTU, DIV and DIVU on forwarded register operands and
//   writes the 64-bit result into the HI/LO registers. Multiplies use a single
//   cycle array multiplier on operand magnitudes; divides use a 32-iteration
//   restoring shift-subtract on operand magnitudes. Signs are fixed up when
//   the result is written. While busy the unit asks the hazard unit to hold
//   the E and D stages.
//
// Ports:
//   clk             in   rising-edge clock
//   resetn          in   asynchronous reset, active low
//   start_i         in   multiply/divide instruction present in E
//   op_i[1:0]       in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a_i[31:0]       in   rs operand (multiplicand / dividend)
//   b_i[31:0]       in   rt operand (multiplier / divisor)
//   flushE          in   E-stage flush (only honoured with MUL_DIV_FLUSH_EN)
//   mut_div_stallE  out  stall request to the hazard unit (combinational)
//   hi_o[31:0]      out  HI register (product high word / remainder)
//   lo_o[31:0]      out  LO register (product low word / quotient)
//   result_valid_o  out  one-cycle pulse in the cycle after hi_o/lo_o update
//
// Configuration:
//   MUL_DIV_FLUSH_EN  when defined, flushE abandons an in-flight operation and
//                     suppresses starting a new one. When undefined, flushE is
//                     ignored and every started operation runs to completion.
// -----------------------------------------------------------------------------
module mul_div_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        flushE,
    output logic        mut_div_stallE,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        result_valid_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } MulDivState;

    MulDivState state;
    MulDivState nextState;

    // Operand magnitude registers. aWork starts as |a| and, during a divide,
    // is shifted left so that the dividend bits leave from the top while the
    // quotient bits enter at the bottom.
    logic [31:0] aWork;
    logic [31:0] bMag;
    logic [31:0] remReg;
    logic [4:0]  divCount;
    logic        negResult;
    logic        negRem;

    // FSM strobes towards the datapath.
    logic        captureOp;
    logic        writeMul;
    logic        writeDiv;
    logic        divStep;
    logic        stallReq;
    logic        validReq;
    logic        flushActive;

    logic        opSigned;
    logic        aNeg;
    logic        bNeg;
    logic [31:0] aMagIn;
    logic [31:0] bMagIn;

    logic [63:0] prodMag;
    logic [63:0] prodFinal;
    logic [32:0] divShifted;
    logic [31:0] divTrial;
    logic        divFits;
    logic [31:0] remNext;
    logic [31:0] quotNext;
    logic [31:0] quotFinal;
    logic [31:0] remFinal;

    // The flush input only has an effect when the feature is built in; in the
    // default build it is tied off so the operation always completes.
`ifdef MUL_DIV_FLUSH_EN
    assign flushActive = flushE;
`else
    logic unusedFlushE;
    assign unusedFlushE = flushE;
    assign flushActive  = 1'b0;
`endif

    // Operand conditioning at capture time: signed ops take magnitudes and
    // remember which result signs must be restored at the end. The product and
    // quotient are negative when the operand signs differ; the remainder
    // follows the dividend.
    always_comb begin
        opSigned = ~op_i[0];
        aNeg     = opSigned & a_i[31];
        bNeg     = opSigned & b_i[31];
        aMagIn   = aNeg ? (32'd0 - a_i) : a_i;
        bMagIn   = bNeg ? (32'd0 - b_i) : b_i;
    end

    // Multiply path: unsigned 64-bit product of the magnitudes, negated as a
    // whole 64-bit value when the result is negative.
    always_comb begin
        prodMag   = {32'd0, aWork} * {32'd0, bMag};
        prodFinal = negResult ? (64'd0 - prodMag) : prodMag;
    end

    // One restoring divide iteration. The partial remainder is shifted left
    // with the next dividend bit; the divisor is subtracted only if it fits.
    // With a zero divisor it always fits, which yields an all-ones quotient
    // and leaves the dividend in the remainder without any special casing.
    always_comb begin
        divShifted = {remReg, aWork[31]};
        divTrial   = divShifted[31:0] - bMag;
        divFits    = (divShifted >= {1'b0, bMag});
        remNext    = divFits ? divTrial : divShifted[31:0];
        quotNext   = {aWork[30:0], divFits};
        quotFinal  = negResult ? (32'd0 - quotNext) : quotNext;
        remFinal   = negRem ? (32'd0 - remNext) : remNext;
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and control decode. A flush overrides everything: it drops
    // the stall immediately, kills any pending write or pulse, and sends the
    // machine back to IDLE. DONE always returns to IDLE so a start_i still
    // high from the same instruction cannot re-trigger it.
    always_comb begin
        nextState = state;
        captureOp = 1'b0;
        writeMul  = 1'b0;
        writeDiv  = 1'b0;
        divStep   = 1'b0;
        stallReq  = 1'b0;
        validReq  = 1'b0;

        case (state)
            IDLE: begin
                if (start_i) begin
                    captureOp = 1'b1;
                    stallReq  = 1'b1;
                    nextState = op_i[1] ? DIV : MUL;
                end
            end
            MUL: begin
                stallReq  = 1'b1;
                writeMul  = 1'b1;
                nextState = DONE;
            end
            DIV: begin
                stallReq = 1'b1;
                divStep  = 1'b1;
                if (divCount == 5'd31) begin
                    writeDiv  = 1'b1;
                    nextState = DONE;
                end
            end
            DONE: begin
                validReq  = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase

        if (flushActive) begin
            nextState = IDLE;
            captureOp = 1'b0;
            writeMul  = 1'b0;
            writeDiv  = 1'b0;
            divStep   = 1'b0;
            stallReq  = 1'b0;
            validReq  = 1'b0;
        end
    end

    // Outputs are gated with resetn so a reset asserted while start_i is still
    // high shows no stall in the same instant.
    assign mut_div_stallE = stallReq & resetn;
    assign result_valid_o = validReq & resetn;

    // Operand capture and divide iteration state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aWork     <= 32'd0;
            bMag      <= 32'd0;
            remReg    <= 32'd0;
            divCount  <= 5'd0;
            negResult <= 1'b0;
            negRem    <= 1'b0;
        end else if (captureOp) begin
            aWork     <= aMagIn;
            bMag      <= bMagIn;
            remReg    <= 32'd0;
            divCount  <= 5'd0;
            negResult <= aNeg ^ bNeg;
            negRem    <= aNeg;
        end else if (divStep) begin
            aWork    <= quotNext;
            remReg   <= remNext;
            divCount <= divCount + 5'd1;
        end
    end

    // HI/LO registers only change on the cycle that leaves MUL or DIV, so
    // they hold the previous result throughout a new operation and on flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_o <= 32'd0;
            lo_o <= 32'd0;
        end else if (writeMul) begin
            hi_o <= prodFinal[63:32];
            lo_o <= prodFinal[31:0];
        end else if (writeDiv) begin
            hi_o <= remFinal;
            lo_o <= quotFinal;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit -- scoreboard bench for mul_div_unit.
//
// A driver issues operations (directed cases, then random ones) and pushes
// the expected {HI,LO} from an arithmetic reference model into a queue. A
// monitor pops and compares each time result_valid_o is seen. The driver
// also checks stall length, HI/LO hold while busy, and reset/flush behaviour.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

    logic        clk;
    logic        resetn;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flushE;
    logic        mut_div_stallE;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        result_valid_o;

    typedef struct {
        logic [63:0] expected;
        string       tag;
    } ScoreEntry;

    ScoreEntry   scoreQ[$];
    int          numTests;
    int          numFail;
    logic [63:0] prevResult;

    mul_div_unit dut (
        .clk            (clk),
        .resetn         (resetn),
        .start_i        (start_i),
        .op_i           (op_i),
        .a_i            (a_i),
        .b_i            (b_i),
        .flushE         (flushE),
        .mut_div_stallE (mut_div_stallE),
        .hi_o           (hi_o),
        .lo_o           (lo_o),
        .result_valid_o (result_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: {HI,LO} straight from the instruction definitions,
    // using 64-bit integer arithmetic (truncating division, remainder takes
    // the dividend's sign). A zero divisor gives an all-ones raw quotient and
    // the dividend magnitude as raw remainder, then the usual sign fixups.
    function automatic logic [63:0] refModel(input logic [1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [31:0] qz;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'd0: return 64'(sa * sb);
            2'd1: return {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) begin
                    qz = 32'hFFFFFFFF;
                    if (a[31]) qz = 32'd0 - qz;
                    return {a, qz};
                end
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        numTests++;
        if (actual !== expected) begin
            numFail++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Issue one instruction and follow it until the stall drops. Operands are
    // scrambled after capture, and start_i stays high into the DONE cycle as
    // if the same instruction were advancing.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input string tag);
        logic [63:0] expResult;
        int          cnt;
        int          expLat;
        @(negedge clk);
        start_i   = 1'b1;
        op_i      = op;
        a_i       = a;
        b_i       = b;
        expResult = refModel(op, a, b);
        scoreQ.push_back('{expResult, tag});
        expLat    = op[1] ? 33 : 2;
        cnt       = 0;
        #1;
        while (mut_div_stallE === 1'b1 && cnt < 100) begin
            cnt++;
            if (cnt == expLat)
                checkOutput({tag, "_hold"}, {hi_o, lo_o}, prevResult);
            @(negedge clk);
            op_i = 2'($urandom);
            a_i  = $urandom;
            b_i  = $urandom;
            #1;
        end
        checkOutput({tag, "_stallCycles"}, 64'(cnt), 64'(expLat));
        checkOutput({tag, "_validPulse"}, {63'd0, result_valid_o}, 64'd1);
        prevResult = expResult;
    endtask

    task automatic idleCycles(input int n);
        @(negedge clk);
        start_i = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    // Monitor: every valid pulse must match the oldest outstanding entry.
    initial begin
        ScoreEntry entry;
        forever begin
            @(negedge clk);
            #2;
            if (resetn === 1'b1 && result_valid_o === 1'b1) begin
                if (scoreQ.size() == 0) begin
                    checkOutput("unexpectedValid", 64'd1, 64'd0);
                end else begin
                    entry = scoreQ.pop_front();
                    checkOutput(entry.tag, {hi_o, lo_o}, entry.expected);
                end
            end
        end
    end

    // Main stimulus sequence.
    initial begin
        numTests   = 0;
        numFail    = 0;
        prevResult = 64'd0;
        resetn     = 1'b0;
        start_i    = 1'b0;
        op_i       = 2'd0;
        a_i        = 32'd0;
        b_i        = 32'd0;
        flushE     = 1'b0;

        #12;
        checkOutput("resetHiLo", {hi_o, lo_o}, 64'd0);
        checkOutput("resetStall", {63'd0, mut_div_stallE}, 64'd0);
        checkOutput("resetValid", {63'd0, result_valid_o}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        idleCycles(2);

        applyStimulus(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "multuMax");
        checkOutput("multuMaxConst", {hi_o, lo_o}, 64'hFFFFFFFE_00000001);
        idleCycles(2);

        applyStimulus(2'd2, 32'hFFFFFFF9, 32'd2, "divNeg7By2");
        checkOutput("divNeg7By2Const", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFD);
        idleCycles(2);

        applyStimulus(2'd3, 32'h12345678, 32'd0, "divuByZero");
        checkOutput("divuByZeroConst", {hi_o, lo_o}, 64'h12345678_FFFFFFFF);
        idleCycles(2);

        applyStimulus(2'd2, 32'h80000000, 32'hFFFFFFFF, "divOverflow");
        checkOutput("divOverflowConst", {hi_o, lo_o}, 64'h00000000_80000000);
        idleCycles(2);

        applyStimulus(2'd2, 32'hFFFFFF00, 32'd0, "divSignedByZero");
        idleCycles(1);

        applyStimulus(2'd0, 32'd3, 32'hFFFFFFFC, "multBackToBack");
        checkOutput("multBackToBackConst", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFF4);
        applyStimulus(2'd3, 32'd100, 32'd7, "divuBackToBack");
        checkOutput("divuBackToBackConst", {hi_o, lo_o}, 64'h00000002_0000000E);
        idleCycles(3);

        // Reset in the middle of a divide: nothing is pushed for it, so any
        // later valid pulse shows up as unexpected in the monitor.
        @(negedge clk);
        start_i = 1'b1;
        op_i    = 2'd2;
        a_i     = 32'd1000;
        b_i     = 32'd3;
        repeat (10) @(negedge clk);
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("midDivResetHiLo", {hi_o, lo_o}, 64'd0);
        checkOutput("midDivResetStall", {63'd0, mut_div_stallE}, 64'd0);
        checkOutput("midDivResetValid", {63'd0, result_valid_o}, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        resetn  = 1'b1;
        prevResult = 64'd0;
        idleCycles(40);

`ifdef MUL_DIV_FLUSH_EN
        applyStimulus(2'd0, 32'd5, 32'd6, "preFlushMult");
        idleCycles(1);
        @(negedge clk);
        start_i = 1'b1;
        op_i    = 2'd2;
        a_i     = 32'd77;
        b_i     = 32'd5;
        repeat (5) @(negedge clk);
        #1;
        flushE = 1'b1;
        #1;
        checkOutput("flushStall", {63'd0, mut_div_stallE}, 64'd0);
        @(negedge clk);
        flushE  = 1'b0;
        start_i = 1'b0;
        #1;
        checkOutput("flushHiLoKept", {hi_o, lo_o}, prevResult);
        idleCycles(40);
        @(negedge clk);
        start_i = 1'b1;
        flushE  = 1'b1;
        op_i    = 2'd1;
        a_i     = 32'd9;
        b_i     = 32'd9;
        #1;
        checkOutput("flushIdleStall", {63'd0, mut_div_stallE}, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        flushE  = 1'b0;
        idleCycles(5);
        checkOutput("flushIdleHiLoKept", {hi_o, lo_o}, prevResult);
`endif

        for (int i = 0; i < 40; i++) begin
            applyStimulus(2'($urandom), randOperand(), randOperand(),
                          $sformatf("rand%0d", i));
            if ($urandom_range(0, 1) == 0)
                idleCycles(int'($urandom_range(1, 3)));
        end

        idleCycles(5);
        checkOutput("scoreboardDrained", 64'(scoreQ.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", numTests, numFail);
        $finish;
    end

endmodule
